// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
//   Shared definitions for the counter load/sequencing controller:
//   FSM state encoding, default datapath width and reload tally width.
package counter_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      RUN  = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int TALLY_WIDTH        = 8;

endpackage : counter_ctrl_pkg

// File: rtl/counter_ctrl_tally.sv
// counter_ctrl_tally
//   Saturating event tally used to count done pulses since the last start.
//   Ports:
//     Clk    - rising-edge clock
//     RST_N  - asynchronous active-low reset (clears the tally)
//     clear  - synchronous clear; has priority over incr
//     incr   - add one to the tally unless it is already at its maximum
//     count  - current tally value
//     sat    - high while the tally sits at its maximum value
module counter_ctrl_tally
   import counter_ctrl_pkg::*;
(
   input  logic                   Clk,
   input  logic                   RST_N,
   input  logic                   clear,
   input  logic                   incr,
   output logic [TALLY_WIDTH-1:0] count,
   output logic                   sat
);

   localparam logic [TALLY_WIDTH-1:0] COUNT_MAX = '1;

   assign sat = (count == COUNT_MAX);

   always_ff @(posedge Clk or negedge RST_N) begin
      if (!RST_N) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (incr && !sat) begin
         count <= count + 1'b1;
      end
   end

endmodule : counter_ctrl_tally

// File: rtl/counter_load_ctrl.sv
// counter_load_ctrl
//   Sequencing controller for a parallel-load up/down counter. Latches a
//   start configuration, loads the counter, enables it until carry/borrow
//   out, then pulses done and either returns to IDLE or reloads.
//   Optional feature macro: CNT_CTRL_RELOAD_TALLY_EN (adds a saturating
//   count of done pulses since the last accepted start).
//   Ports:
//     Clk, RST_N          - clock, asynchronous active-low reset
//     start_i, stop_i     - start request (IDLE only), abort request
//     cfg_preset_i        - preset value, latched on accepted start
//     cfg_dir_i           - direction, latched on start (1 = up)
//     cfg_auto_reload_i   - reload mode, latched on start (1 = reload)
//     cnt_value_i         - counter value, registered onto value_o
//     cnt_cout_i          - counter carry/borrow out (terminal count)
//     cnt_load_o, cnt_data_o, cnt_dir_o, cnt_en_o - counter controls
//     busy_o, done_o      - status: not IDLE, one-cycle terminal pulse
//     value_o             - cnt_value_i delayed by one cycle
//     reload_cnt_o, tally_sat_o - (macro only) done tally and saturation
module counter_load_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
)
(
   input  logic                   Clk,
   input  logic                   RST_N,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic [DATA_WIDTH-1:0]  cfg_preset_i,
   input  logic                   cfg_dir_i,
   input  logic                   cfg_auto_reload_i,
   input  logic [DATA_WIDTH-1:0]  cnt_value_i,
   input  logic                   cnt_cout_i,
   output logic                   cnt_load_o,
   output logic [DATA_WIDTH-1:0]  cnt_data_o,
   output logic                   cnt_dir_o,
   output logic                   cnt_en_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [DATA_WIDTH-1:0]  value_o
`ifdef CNT_CTRL_RELOAD_TALLY_EN
   ,
   output logic [TALLY_WIDTH-1:0] reload_cnt_o,
   output logic                   tally_sat_o
`endif
);

   state_t                state;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] preset_q;
   logic                  dir_q;
   logic                  auto_reload_q;
   logic                  busy;
   logic                  start_accept;

   assign start_accept = (state == IDLE) && start_i;

   // Next-state logic. stop_i wins over cnt_cout_i so an abort at terminal
   // count never produces a done pulse.
   always_comb begin
      // NOTE: default assigned first so every path drives state_next and
      // no latch is inferred.
      state_next = state;
      unique case (state)
         IDLE: if (start_i) state_next = LOAD;
         LOAD: state_next = stop_i ? IDLE : RUN;
         RUN: begin
            if (stop_i)          state_next = IDLE;
            else if (cnt_cout_i) state_next = DONE;
         end
         DONE: begin
            if (stop_i)             state_next = IDLE;
            else if (auto_reload_q) state_next = LOAD;
            else                    state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Moore outputs decoded from the state register only. Data and direction
   // are gated so every counter control reads 0 while IDLE.
   assign busy       = (state != IDLE);
   assign busy_o     = busy;
   assign cnt_load_o = (state == LOAD);
   assign cnt_en_o   = (state == RUN);
   assign cnt_data_o = busy ? preset_q : '0;
   assign cnt_dir_o  = busy & dir_q;

   // NOTE: non-blocking assignments for all registered state so every
   // flop samples pre-edge values regardless of statement order.
   always_ff @(posedge Clk or negedge RST_N) begin
      if (!RST_N) begin
         state         <= IDLE;
         preset_q      <= '0;
         dir_q         <= 1'b0;
         auto_reload_q <= 1'b0;
         done_o        <= 1'b0;
         value_o       <= '0;
      end else begin
         state   <= state_next;
         // done_o is registered but high exactly while the FSM sits in DONE.
         done_o  <= (state_next == DONE);
         value_o <= cnt_value_i;
         if (start_accept) begin
            preset_q      <= cfg_preset_i;
            dir_q         <= cfg_dir_i;
            auto_reload_q <= cfg_auto_reload_i;
         end
      end
   end

`ifdef CNT_CTRL_RELOAD_TALLY_EN
   // done_o is high for one cycle per terminal count, so it is the tally's
   // increment; a start clears the tally for the new run.
   counter_ctrl_tally u_tally (
      .Clk   (Clk),
      .RST_N (RST_N),
      .clear (start_accept),
      .incr  (done_o),
      .count (reload_cnt_o),
      .sat   (tally_sat_o)
   );
`endif

endmodule : counter_load_ctrl

// File: tb/tb_counter_load_ctrl.sv
// tb_counter_load_ctrl
//   Self-checking bench for counter_load_ctrl with an attached behavioural
//   up/down counter. Expected output timelines are derived from the run
//   length of each configuration (2^W - P up, P + 1 down).
module tb_counter_load_ctrl;

   logic       Clk = 1'b0;
   logic       RST_N;
   logic       start_i, stop_i;
   logic [7:0] cfg_preset_i;
   logic       cfg_dir_i, cfg_auto_reload_i;
   logic [7:0] cnt_value_i;
   logic       cnt_cout_i;
   logic       cnt_load_o, cnt_dir_o, cnt_en_o, busy_o, done_o;
   logic [7:0] cnt_data_o, value_o;
`ifdef CNT_CTRL_RELOAD_TALLY_EN
   logic [7:0] reload_cnt_o;
   logic       tally_sat_o;
`endif

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   counter_load_ctrl #(.DATA_WIDTH(8)) dut (
      .Clk               (Clk),
      .RST_N             (RST_N),
      .start_i           (start_i),
      .stop_i            (stop_i),
      .cfg_preset_i      (cfg_preset_i),
      .cfg_dir_i         (cfg_dir_i),
      .cfg_auto_reload_i (cfg_auto_reload_i),
      .cnt_value_i       (cnt_value_i),
      .cnt_cout_i        (cnt_cout_i),
      .cnt_load_o        (cnt_load_o),
      .cnt_data_o        (cnt_data_o),
      .cnt_dir_o         (cnt_dir_o),
      .cnt_en_o          (cnt_en_o),
      .busy_o            (busy_o),
      .done_o            (done_o),
      .value_o           (value_o)
`ifdef CNT_CTRL_RELOAD_TALLY_EN
      ,
      .reload_cnt_o      (reload_cnt_o),
      .tally_sat_o       (tally_sat_o)
`endif
   );

   // Behavioural parallel-load up/down counter driven by the DUT.
   logic [7:0] cnt      = 8'h00;
   logic [7:0] cnt_prev = 8'h00;

   always @(posedge Clk or negedge RST_N) begin
      if (!RST_N) begin
         cnt_prev <= 8'h00;
      end else begin
         cnt_prev <= cnt;
         if (cnt_load_o)    cnt <= cnt_data_o;
         else if (cnt_en_o) cnt <= cnt_dir_o ? cnt + 8'd1 : cnt - 8'd1;
      end
   end

   assign cnt_value_i = cnt;
   assign cnt_cout_i  = cnt_en_o && (cnt_dir_o ? (cnt == 8'hFF) : (cnt == 8'h00));

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic expect_cycle(input string ph, input int load, input int en,
                               input int done, input int busy, input int data,
                               input int dir);
      check({ph, ".load"},  int'(cnt_load_o), load);
      check({ph, ".en"},    int'(cnt_en_o),   en);
      check({ph, ".done"},  int'(done_o),     done);
      check({ph, ".busy"},  int'(busy_o),     busy);
      check({ph, ".data"},  int'(cnt_data_o), data);
      check({ph, ".dir"},   int'(cnt_dir_o),  dir);
      check({ph, ".value"}, int'(value_o),    int'(cnt_prev));
   endtask

   // One start from IDLE, then 'periods' terminal counts. Auto-reload runs
   // are aborted with stop_i in the LOAD cycle after the last done pulse.
   // poke: re-issue start with preset 8'h10 during the first RUN cycle.
   task automatic run_txn(input logic [7:0] p, input logic d, input logic a,
                          input int periods, input logic poke);
      int r;
      int tally_exp;
      r = d ? (256 - int'(p)) : (int'(p) + 1);
      tally_exp = (periods > 255) ? 255 : periods;
      start_i = 1'b1; cfg_preset_i = p; cfg_dir_i = d; cfg_auto_reload_i = a;
      @(negedge Clk);
      // Scramble the config inputs: the DUT must use the latched copy.
      start_i = 1'b0; cfg_preset_i = 8'($urandom); cfg_dir_i = ~d; cfg_auto_reload_i = ~a;
      for (int k = 0; k < periods; k++) begin
         expect_cycle("load", 1, 0, 0, 1, int'(p), int'(d));
         @(negedge Clk);
         for (int j = 0; j < r; j++) begin
            if (poke && k == 0 && j == 0) begin
               start_i = 1'b1; cfg_preset_i = 8'h10; cfg_auto_reload_i = 1'b1;
            end
            expect_cycle("run", 0, 1, 0, 1, int'(p), int'(d));
            if (j == r - 1) check("cout_last_run", int'(cnt_cout_i), 1);
            @(negedge Clk);
            start_i = 1'b0;
         end
         expect_cycle("done", 0, 0, 1, 1, int'(p), int'(d));
         @(negedge Clk);
      end
      if (a) begin
         expect_cycle("reload", 1, 0, 0, 1, int'(p), int'(d));
         stop_i = 1'b1;
         @(negedge Clk);
         stop_i = 1'b0;
      end
      expect_cycle("idle", 0, 0, 0, 0, 0, 0);
`ifdef CNT_CTRL_RELOAD_TALLY_EN
      check("tally", int'(reload_cnt_o), tally_exp);
      check("tally_sat", int'(tally_sat_o), (tally_exp == 255) ? 1 : 0);
`endif
      @(negedge Clk);
   endtask

   // stop_i arrives together with cnt_cout_i: no done pulse, straight to IDLE.
   task automatic stop_at_cout();
      start_i = 1'b1; cfg_preset_i = 8'h02; cfg_dir_i = 1'b0; cfg_auto_reload_i = 1'b1;
      @(negedge Clk);
      start_i = 1'b0;
      expect_cycle("sc_load", 1, 0, 0, 1, 2, 0);
      @(negedge Clk);
      for (int j = 0; j < 3; j++) begin
         expect_cycle("sc_run", 0, 1, 0, 1, 2, 0);
         if (j == 2) begin
            check("sc_cout", int'(cnt_cout_i), 1);
            stop_i = 1'b1;
         end
         @(negedge Clk);
      end
      stop_i = 1'b0;
      expect_cycle("sc_after", 0, 0, 0, 0, 0, 0);
      @(negedge Clk);
      expect_cycle("sc_after2", 0, 0, 0, 0, 0, 0);
`ifdef CNT_CTRL_RELOAD_TALLY_EN
      check("sc_tally", int'(reload_cnt_o), 0);
`endif
      @(negedge Clk);
   endtask

   // Asynchronous reset in the middle of RUN; no resumption without start.
   task automatic reset_mid_run();
      start_i = 1'b1; cfg_preset_i = 8'h00; cfg_dir_i = 1'b1; cfg_auto_reload_i = 1'b1;
      @(negedge Clk);
      start_i = 1'b0;
      @(negedge Clk);
      for (int j = 0; j < 4; j++) @(negedge Clk);
      check("rst_pre_en", int'(cnt_en_o), 1);
      #2 RST_N = 1'b0;
      #1;
      check("rst_load",  int'(cnt_load_o), 0);
      check("rst_en",    int'(cnt_en_o),   0);
      check("rst_busy",  int'(busy_o),     0);
      check("rst_done",  int'(done_o),     0);
      check("rst_data",  int'(cnt_data_o), 0);
      check("rst_dir",   int'(cnt_dir_o),  0);
      check("rst_value", int'(value_o),    0);
`ifdef CNT_CTRL_RELOAD_TALLY_EN
      check("rst_tally", int'(reload_cnt_o), 0);
`endif
      @(negedge Clk);
      RST_N = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge Clk);
         expect_cycle("rst_idle", 0, 0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      RST_N = 1'b0;
      start_i = 1'b0; stop_i = 1'b0;
      cfg_preset_i = 8'h00; cfg_dir_i = 1'b0; cfg_auto_reload_i = 1'b0;
      #12;
      check("reset_busy", int'(busy_o),     0);
      check("reset_load", int'(cnt_load_o), 0);
      check("reset_en",   int'(cnt_en_o),   0);
      check("reset_done", int'(done_o),     0);
      check("reset_data", int'(cnt_data_o), 0);
      @(negedge Clk);
      RST_N = 1'b1;
      @(negedge Clk);

      run_txn(8'hFC, 1'b1, 1'b0, 1, 1'b0);  // up one-shot: 4 RUN cycles
      run_txn(8'h00, 1'b0, 1'b0, 1, 1'b0);  // down from zero: 1 RUN cycle
      run_txn(8'hFF, 1'b1, 1'b0, 1, 1'b0);  // up from all-ones: 1 RUN cycle
      run_txn(8'h03, 1'b0, 1'b1, 3, 1'b0);  // down auto-reload: period 6
      stop_at_cout();
      run_txn(8'h20, 1'b1, 1'b0, 1, 1'b1);  // start while busy is ignored
      run_txn(8'h10, 1'b0, 1'b0, 1, 1'b0);  // new preset accepted from IDLE
      reset_mid_run();

      for (int i = 0; i < 6; i++) begin
         logic [7:0] p;
         logic       d, a;
         p = 8'($urandom_range(0, 255));
         d = 1'($urandom_range(0, 1));
         a = 1'($urandom_range(0, 1));
         run_txn(p, d, a, a ? int'($urandom_range(1, 3)) : 1, 1'($urandom_range(0, 1)));
      end

      run_txn(8'hFF, 1'b1, 1'b1, 260, 1'b0);  // tally saturation

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_counter_load_ctrl
